// File: rtl/instr_encode_if.sv
// instr_encode_if: request fields plus both valid/ready handshakes of the instruction encoder.
interface instr_encode_if;
  logic        i_valid;
  logic        o_in_ready;
  logic [2:0]  i_fmt;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [31:0] i_imm;
  logic        o_valid;
  logic        i_out_ready;
  logic [31:0] o_instr;
  logic        o_err;
  logic [7:0]  o_err_count;
  modport master (
    output i_valid, i_fmt, i_opcode, i_funct3, i_funct7, i_rd, i_rs1, i_rs2, i_imm, i_out_ready,
    input  o_in_ready, o_valid, o_instr, o_err, o_err_count
  );
  modport slave (
    input  i_valid, i_fmt, i_opcode, i_funct3, i_funct7, i_rd, i_rs1, i_rs2, i_imm, i_out_ready,
    output o_in_ready, o_valid, o_instr, o_err, o_err_count
  );
endinterface

// File: rtl/instr_encode.sv
// instr_encode: RV32I word assembly with immediate range checks and a 2-entry output queue.
module instr_encode (
  input logic          i_clk,
  input logic          i_rst,
  instr_encode_if.slave enc
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] imm;
  logic        ok_is, ok_b, ok_u, ok_j;
  logic [31:0] word;
  logic        err;
  logic [31:0] q_word [2];
  logic [1:0]  q_err;
  logic        rp, wp;
  logic [1:0]  count;
  logic [7:0]  err_count;
  logic        push, pop;
  assign imm   = enc.i_imm;
  assign ok_is = &imm[31:11] | ~|imm[31:11];
  assign ok_b  = (&imm[31:12] | ~|imm[31:12]) & ~imm[0];
  assign ok_u  = ~|imm[11:0];
  assign ok_j  = (&imm[31:20] | ~|imm[31:20]) & ~imm[0];
  always_comb begin
    word = NOP;
    err  = 1'b0;
    case (enc.i_fmt)
      3'd0: word = {enc.i_funct7, enc.i_rs2, enc.i_rs1, enc.i_funct3, enc.i_rd, enc.i_opcode};
      3'd1: begin
        err  = ~ok_is;
        word = {imm[11:0], enc.i_rs1, enc.i_funct3, enc.i_rd, enc.i_opcode};
      end
      3'd2: begin
        err  = ~ok_is;
        word = {imm[11:5], enc.i_rs2, enc.i_rs1, enc.i_funct3, imm[4:0], enc.i_opcode};
      end
      3'd3: begin
        err  = ~ok_b;
        word = {imm[12], imm[10:5], enc.i_rs2, enc.i_rs1, enc.i_funct3, imm[4:1], imm[11], enc.i_opcode};
      end
      3'd4: begin
        err  = ~ok_u;
        word = {imm[31:12], enc.i_rd, enc.i_opcode};
      end
      3'd5: begin
        err  = ~ok_j;
        word = {imm[20], imm[10:1], imm[11], imm[19:12], enc.i_rd, enc.i_opcode};
      end
      default: err = 1'b1;
    endcase
    word = err ? NOP : word;
  end
  // in_ready depends only on stored count, so a pop at full never admits a push that cycle
  assign enc.o_in_ready  = count != 2'd2;
  assign enc.o_valid     = count != 2'd0;
  assign enc.o_instr     = q_word[rp];
  assign enc.o_err       = q_err[rp];
  assign enc.o_err_count = err_count;
  assign push = enc.i_valid & enc.o_in_ready;
  assign pop  = enc.o_valid & enc.i_out_ready;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      q_word[0] <= '0;
      q_word[1] <= '0;
      q_err     <= '0;
      rp        <= 1'b0;
      wp        <= 1'b0;
      count     <= '0;
      err_count <= '0;
    end else begin
      if (push) begin
        q_word[wp] <= word;
        q_err[wp]  <= err;
        wp         <= ~wp;
        if (err && err_count != 8'hff) err_count <= err_count + 8'd1;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_instr_encode.sv
// tb_instr_encode: table-driven encoding vectors plus backpressure, reset and saturation sequences.
module tb_instr_encode;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int checks = 0;
  int failures = 0;
  instr_encode_if bus();
  instr_encode dut (.i_clk(i_clk), .i_rst(i_rst), .enc(bus));
  always #5 i_clk = ~i_clk;
  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
    logic        err;
  } vec_t;
  vec_t vt [20];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    bus.i_fmt    = v.fmt;
    bus.i_opcode = v.op;
    bus.i_funct3 = v.f3;
    bus.i_funct7 = v.f7;
    bus.i_rd     = v.rd;
    bus.i_rs1    = v.rs1;
    bus.i_rs2    = v.rs2;
    bus.i_imm    = v.imm;
  endtask
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  initial begin
    int exp_ec;
    vt[0]  = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0, 32'h0000_0005, 32'h0050_0093, 1'b0};
    vt[1]  = '{3'd0, 7'h33, 3'd0, 7'h00, 5'd3,  5'd1,  5'd2, 32'h0000_0000, 32'h0020_81B3, 1'b0};
    vt[2]  = '{3'd2, 7'h23, 3'd2, 7'h00, 5'd31, 5'd1,  5'd2, 32'h0000_0008, 32'h0020_A423, 1'b0};
    vt[3]  = '{3'd4, 7'h37, 3'd7, 7'h00, 5'd5,  5'd31, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
    vt[4]  = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0, 32'hFFFF_FFFC, 32'hFFDF_F06F, 1'b0};
    vt[5]  = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0,  5'd1,  5'd2, 32'h0000_0003, 32'h0000_0013, 1'b1};
    vt[6]  = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0, 32'h0000_0800, 32'h0000_0013, 1'b1};
    vt[7]  = '{3'd0, 7'h33, 3'd0, 7'h20, 5'd3,  5'd1,  5'd2, 32'h0000_0000, 32'h4020_81B3, 1'b0};
    vt[8]  = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0,  5'd1,  5'd2, 32'h0000_0008, 32'h0020_8463, 1'b0};
    vt[9]  = '{3'd3, 7'h63, 3'd1, 7'h00, 5'd0,  5'd1,  5'd2, 32'hFFFF_FFF8, 32'hFE20_9CE3, 1'b0};
    vt[10] = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0};
    vt[11] = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0, 32'hFFFF_F7FF, 32'h0000_0013, 1'b1};
    vt[12] = '{3'd2, 7'h23, 3'd2, 7'h00, 5'd0,  5'd1,  5'd2, 32'hFFFF_FFFC, 32'hFE20_AE23, 1'b0};
    vt[13] = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5,  5'd0,  5'd0, 32'h1234_5001, 32'h0000_0013, 1'b1};
    vt[14] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0, 32'hFFF0_0000, 32'h8000_006F, 1'b0};
    vt[15] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0, 32'h0010_0000, 32'h0000_0013, 1'b1};
    vt[16] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0, 32'h0000_0005, 32'h0000_0013, 1'b1};
    vt[17] = '{3'd6, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0, 32'h0000_0000, 32'h0000_0013, 1'b1};
    vt[18] = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0, 32'hFFFF_F000, 32'h8000_0063, 1'b0};
    vt[19] = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0, 32'h0000_1000, 32'h0000_0013, 1'b1};
    bus.i_valid = 1'b0;
    bus.i_out_ready = 1'b1;
    drive(vt[0]);
    repeat (2) tick;
    chk("reset_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.o_in_ready}, 32'd1);
    chk("reset_instr", bus.o_instr, 32'd0);
    chk("reset_err", {31'd0, bus.o_err}, 32'd0);
    chk("reset_err_count", {24'd0, bus.o_err_count}, 32'd0);
    i_rst = 1'b0;
    tick;
    exp_ec = 0;
    for (int i = 0; i < 20; i++) begin
      drive(vt[i]);
      bus.i_valid = 1'b1;
      tick;
      exp_ec += int'(vt[i].err);
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.o_valid}, 32'd1);
      chk($sformatf("vec%0d_instr", i), bus.o_instr, vt[i].word);
      chk($sformatf("vec%0d_err", i), {31'd0, bus.o_err}, {31'd0, vt[i].err});
      chk($sformatf("vec%0d_err_count", i), {24'd0, bus.o_err_count}, exp_ec);
    end
    bus.i_valid = 1'b0;
    tick;
    chk("drain_valid", {31'd0, bus.o_valid}, 32'd0);
    repeat (3) tick;
    chk("idle_ready_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("idle_ready_in_ready", {31'd0, bus.o_in_ready}, 32'd1);
    // backpressure: A, B absorbed, C held until the first pop from full
    bus.i_out_ready = 1'b0;
    drive(vt[1]);
    bus.i_valid = 1'b1;
    tick;
    chk("bp_in_ready_1", {31'd0, bus.o_in_ready}, 32'd1);
    chk("bp_head_1", bus.o_instr, vt[1].word);
    drive(vt[2]);
    tick;
    chk("bp_in_ready_2", {31'd0, bus.o_in_ready}, 32'd0);
    drive(vt[3]);
    repeat (2) tick;
    chk("bp_held_in_ready", {31'd0, bus.o_in_ready}, 32'd0);
    chk("bp_stable_head", bus.o_instr, vt[1].word);
    bus.i_out_ready = 1'b1;
    tick;
    chk("bp_pop1_head", bus.o_instr, vt[2].word);
    chk("bp_pop1_in_ready", {31'd0, bus.o_in_ready}, 32'd1);
    tick;
    bus.i_valid = 1'b0;
    chk("bp_pop2_head", bus.o_instr, vt[3].word);
    chk("bp_pop2_valid", {31'd0, bus.o_valid}, 32'd1);
    tick;
    chk("bp_empty", {31'd0, bus.o_valid}, 32'd0);
    // async reset with two words queued and a nonzero error count
    bus.i_out_ready = 1'b0;
    drive(vt[17]);
    bus.i_valid = 1'b1;
    repeat (2) tick;
    bus.i_valid = 1'b0;
    chk("pre_rst_full", {31'd0, bus.o_in_ready}, 32'd0);
    #2 i_rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_async_in_ready", {31'd0, bus.o_in_ready}, 32'd1);
    chk("rst_async_err_count", {24'd0, bus.o_err_count}, 32'd0);
    chk("rst_async_instr", bus.o_instr, 32'd0);
    tick;
    i_rst = 1'b0;
    tick;
    chk("post_rst_valid", {31'd0, bus.o_valid}, 32'd0);
    // saturation of the error counter
    bus.i_out_ready = 1'b1;
    drive(vt[17]);
    bus.i_fmt = 3'd7;
    bus.i_valid = 1'b1;
    repeat (254) tick;
    chk("sat_254", {24'd0, bus.o_err_count}, 32'd254);
    tick;
    chk("sat_255", {24'd0, bus.o_err_count}, 32'd255);
    repeat (45) tick;
    bus.i_valid = 1'b0;
    chk("sat_hold", {24'd0, bus.o_err_count}, 32'd255);
    chk("sat_instr", bus.o_instr, 32'h0000_0013);
    chk("sat_err", {31'd0, bus.o_err}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
